// File: rtl/vga_cell_framebuffer_pkg.sv
// Shared definitions for the cell framebuffer: default geometry, colour
// constants and the fill FSM state type.
package vga_cell_framebuffer_pkg;

  localparam int unsigned DEF_H_CELLS   = 80;
  localparam int unsigned DEF_V_CELLS   = 60;
  localparam int unsigned DEF_CELL_BITS = 3;

  typedef logic [2:0] color_t;

  localparam color_t BLACK   = 3'b000;
  localparam color_t BLUE    = 3'b001;
  localparam color_t GREEN   = 3'b010;
  localparam color_t CYAN    = 3'b011;
  localparam color_t RED     = 3'b100;
  localparam color_t MAGENTA = 3'b101;
  localparam color_t YELLOW  = 3'b110;
  localparam color_t WHITE   = 3'b111;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } fb_state_t;

endpackage

// File: rtl/vga_cell_framebuffer_if.sv
// Host-side write/clear bus of the cell framebuffer.
interface vga_cell_framebuffer_if;
  logic       iWriteValid;
  logic [6:0] iWriteCol;
  logic [5:0] iWriteRow;
  logic [2:0] iWriteColor;
  logic       oWriteReady;
  logic       iClear;
  logic [2:0] iClearColor;
  logic       oBusy;

  modport master (
    output iWriteValid, iWriteCol, iWriteRow, iWriteColor, iClear, iClearColor,
    input  oWriteReady, oBusy
  );

  modport slave (
    input  iWriteValid, iWriteCol, iWriteRow, iWriteColor, iClear, iClearColor,
    output oWriteReady, oBusy
  );
endinterface

// File: rtl/vga_cell_ram.sv
// Simple dual-port colour RAM: one write port, one registered read port
// with read-first behaviour on address collisions.
module vga_cell_ram
  import vga_cell_framebuffer_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_H_CELLS * DEF_V_CELLS,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  color_t            i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output color_t            o_rdata
);

  color_t r_mem [DEPTH];
  color_t r_rdata;

  // NOTE: the array has no reset so it maps onto block RAM; only the
  // surrounding control logic is reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_cell_framebuffer.sv
// Cell-based framebuffer: 8x8-pixel cells of 3-bit colour, host writes,
// whole-buffer fill FSM, and a 2-stage pixel read pipeline for a VGA timer.
module vga_cell_framebuffer
  import vga_cell_framebuffer_pkg::*;
#(
  parameter int unsigned H_CELLS   = DEF_H_CELLS,
  parameter int unsigned V_CELLS   = DEF_V_CELLS,
  parameter int unsigned CELL_BITS = DEF_CELL_BITS
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [9:0]            iColumn,
  input  logic [9:0]            iRow,
  input  logic                  iVisible,
  output logic [2:0]            oPixel,
  vga_cell_framebuffer_if.slave host
);

  localparam int unsigned       CELLS     = H_CELLS * V_CELLS;
  localparam int unsigned       ADDR_W    = $clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [10:0]       H_PIX     = 11'(H_CELLS << CELL_BITS);
  localparam logic [10:0]       V_PIX     = 11'(V_CELLS << CELL_BITS);
  localparam logic [7:0]        H_LIM     = 8'(H_CELLS);
  localparam logic [6:0]        V_LIM     = 7'(V_CELLS);

  // row*H_CELLS + col built from the set bits of the constant H_CELLS.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] row,
                                                  input logic [9:0] col);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(col);
    for (int i = 0; i < 10; i++)
      if (H_CELLS[i]) acc = acc + (ADDR_W'(row) << i);
    return acc;
  endfunction

  fb_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
  color_t            r_fill_color, w_fill_color_nxt;

  logic              w_ready, w_wr_in_range;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  color_t            w_wr_data;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  color_t            r_wr_data;

  logic              w_rd_valid;
  logic              r_rd_valid, r_px_valid;
  logic [ADDR_W-1:0] r_rd_addr;
  color_t            w_ram_q;

  assign w_ready          = (r_state == ST_IDLE) && Reset;
  assign host.oWriteReady = w_ready;
  assign host.oBusy       = (r_state == ST_CLEAR);

  assign w_wr_in_range = ({1'b0, host.iWriteCol} < H_LIM) &&
                         ({1'b0, host.iWriteRow} < V_LIM);

  // NOTE: every signal gets its default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_fill_cnt_nxt   = r_fill_cnt;
    w_fill_color_nxt = r_fill_color;
    w_wr_en          = 1'b0;
    w_wr_addr        = cell_addr({4'd0, host.iWriteRow}, {3'd0, host.iWriteCol});
    w_wr_data        = host.iWriteColor;
    unique case (r_state)
      ST_IDLE: begin
        w_wr_en = host.iWriteValid && w_ready && w_wr_in_range;
        if (host.iClear) begin
          w_state_nxt      = ST_CLEAR;
          w_fill_cnt_nxt   = '0;
          w_fill_color_nxt = host.iClearColor;
        end
      end
      ST_CLEAR: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_fill_cnt;
        w_wr_data = r_fill_color;
        if (r_fill_cnt == LAST_ADDR) w_state_nxt    = ST_IDLE;
        else                         w_fill_cnt_nxt = r_fill_cnt + 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state      <= ST_IDLE;
      r_fill_cnt   <= '0;
      r_fill_color <= BLACK;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_cnt   <= w_fill_cnt_nxt;
      r_fill_color <= w_fill_color_nxt;
    end
  end

  assign w_rd_valid = iVisible && ({1'b0, iColumn} < H_PIX) && ({1'b0, iRow} < V_PIX);

  // Writes reach the RAM one edge after acceptance, so a read sampled on the
  // accepting edge still sees the old cell while later reads see the new one.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= BLACK;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_px_valid <= 1'b0;
    end else begin
      r_wr_en    <= w_wr_en;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= w_wr_data;
      r_rd_valid <= w_rd_valid;
      r_rd_addr  <= w_rd_valid ? cell_addr(iRow >> CELL_BITS, iColumn >> CELL_BITS) : '0;
      r_px_valid <= r_rd_valid;
    end
  end

  vga_cell_ram #(
    .DEPTH  (CELLS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (Clock),
    .i_we    (r_wr_en),
    .i_waddr (r_wr_addr),
    .i_wdata (r_wr_data),
    .i_raddr (r_rd_addr),
    .o_rdata (w_ram_q)
  );

  assign oPixel = r_px_valid ? w_ram_q : BLACK;

endmodule

// File: tb/tb_vga_cell_framebuffer.sv
// Self-checking bench for vga_cell_framebuffer: directed fill/reset/write
// sequences, a vector table for the read path, and a randomised run
// against a cell-array reference model.
module tb_vga_cell_framebuffer;
  import vga_cell_framebuffer_pkg::*;

  localparam int HC = 80;
  localparam int VC = 60;
  localparam int NCELLS = HC * VC;

  logic       clk;
  logic       rst_n;
  logic [9:0] px_col, px_row;
  logic       px_vis;
  logic [2:0] px_out;

  vga_cell_framebuffer_if host_if ();

  vga_cell_framebuffer dut (
    .Clock   (clk),
    .Reset   (rst_n),
    .iColumn (px_col),
    .iRow    (px_row),
    .iVisible(px_vis),
    .oPixel  (px_out),
    .host    (host_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [9:0] col;
    logic [9:0] row;
    logic       vis;
    color_t     exp;
  } vec_t;

  typedef struct {
    logic       wv;
    color_t     wcolor;
    logic [9:0] col;
    logic [9:0] row;
    color_t     exp;
  } rw_vec_t;

  // Reference model: one colour per cell plus fill progress.
  color_t model [NCELLS];
  bit     m_busy;
  int     m_fill_idx;
  color_t m_fill_color;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_px(input logic [9:0] c, input logic [9:0] r, input logic v,
                         output color_t p);
    px_col = c; px_row = r; px_vis = v;
    step(); step();
    p = px_out;
  endtask

  task automatic host_write(input int c, input int r, input color_t color);
    host_if.iWriteCol   = 7'(c);
    host_if.iWriteRow   = 6'(r);
    host_if.iWriteColor = color;
    host_if.iWriteValid = 1'b1;
    step();
    host_if.iWriteValid = 1'b0;
  endtask

  task automatic do_fill(input color_t c, input bit hold_wr,
                         output int busy_cycles, output int ready_hits);
    host_if.iClear      = 1'b1;
    host_if.iClearColor = c;
    step();
    host_if.iClear      = 1'b0;
    host_if.iClearColor = ~c;
    host_if.iWriteValid = hold_wr;
    busy_cycles = 0;
    ready_hits  = 0;
    while (host_if.oBusy && busy_cycles < 6000) begin
      if (host_if.oWriteReady) ready_hits++;
      busy_cycles++;
      step();
    end
  endtask

  function automatic color_t exp_pixel(input int c, input int r, input bit v);
    if (!v || c >= HC * 8 || r >= VC * 8) return BLACK;
    return model[(r / 8) * HC + (c / 8)];
  endfunction

  task automatic model_edge(input bit wv, input int wc, input int wr, input color_t wcol,
                            input bit clr, input color_t ccol);
    if (m_busy) begin
      model[m_fill_idx] = m_fill_color;
      m_fill_idx++;
      if (m_fill_idx == NCELLS) m_busy = 0;
    end else begin
      if (wv && wc < HC && wr < VC) model[wr * HC + wc] = wcol;
      if (clr) begin
        m_busy = 1; m_fill_idx = 0; m_fill_color = ccol;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t    vecs [14];
    rw_vec_t rwv [4];
    color_t  p;
    int      busy_n, ready_n;
    color_t  exp_q [$];

    px_col = '0; px_row = '0; px_vis = 1'b0;
    host_if.iWriteValid = 1'b0; host_if.iWriteCol = '0; host_if.iWriteRow = '0;
    host_if.iWriteColor = BLACK; host_if.iClear = 1'b0; host_if.iClearColor = BLACK;

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_busy", host_if.oBusy, 0);
    check("rst_ready", host_if.oWriteReady, 0);
    check("rst_pixel", px_out, BLACK);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", host_if.oWriteReady, 1);
    check("post_rst_busy", host_if.oBusy, 0);

    // Fill with red while a write to cell (10,10) is held pending
    host_if.iWriteCol = 7'd10; host_if.iWriteRow = 6'd10; host_if.iWriteColor = BLUE;
    do_fill(RED, 1'b1, busy_n, ready_n);
    check("fill_red_busy_cycles", busy_n, 4800);
    check("fill_ready_low", ready_n, 0);
    check("after_fill_ready", host_if.oWriteReady, 1);
    step();
    host_if.iWriteValid = 1'b0;
    read_px(10'd0, 10'd0, 1'b1, p);       check("red_0_0", p, RED);
    read_px(10'd639, 10'd479, 1'b1, p);   check("red_639_479", p, RED);
    read_px(10'd85, 10'd82, 1'b1, p);     check("held_write_visible", p, BLUE);
    read_px(10'd88, 10'd82, 1'b1, p);     check("held_write_neighbour", p, RED);

    // Clear to black, write a few cells, then apply the read vector table
    do_fill(BLACK, 1'b0, busy_n, ready_n);
    check("fill_black_busy_cycles", busy_n, 4800);
    host_write(5, 2, GREEN);
    host_write(0, 0, WHITE);
    host_write(79, 59, YELLOW);
    host_write(80, 2, RED);   // out of range: discarded
    host_write(6, 60, RED);   // out of range: discarded

    vecs[0]  = '{10'd40,   10'd16,   1'b1, GREEN};
    vecs[1]  = '{10'd47,   10'd23,   1'b1, GREEN};
    vecs[2]  = '{10'd44,   10'd19,   1'b1, GREEN};
    vecs[3]  = '{10'd48,   10'd16,   1'b1, BLACK};
    vecs[4]  = '{10'd39,   10'd23,   1'b1, BLACK};
    vecs[5]  = '{10'd40,   10'd24,   1'b1, BLACK};
    vecs[6]  = '{10'd0,    10'd0,    1'b1, WHITE};
    vecs[7]  = '{10'd0,    10'd0,    1'b0, BLACK};
    vecs[8]  = '{10'd639,  10'd479,  1'b1, YELLOW};
    vecs[9]  = '{10'd639,  10'd479,  1'b0, BLACK};
    vecs[10] = '{10'd640,  10'd479,  1'b1, BLACK};
    vecs[11] = '{10'd639,  10'd480,  1'b1, BLACK};
    vecs[12] = '{10'd1023, 10'd1023, 1'b1, BLACK};
    vecs[13] = '{10'd47,   10'd15,   1'b1, BLACK};

    for (int i = 0; i <= 14; i++) begin
      if (i < 14) begin
        px_col = vecs[i].col; px_row = vecs[i].row; px_vis = vecs[i].vis;
      end else px_vis = 1'b0;
      step();
      if (i >= 1) check($sformatf("vec%0d", i - 1), px_out, vecs[i - 1].exp);
    end

    // Reset in the middle of a fill, then a complete fill afterwards
    host_if.iClear = 1'b1; host_if.iClearColor = GREEN;
    step();
    host_if.iClear = 1'b0;
    repeat (100) step();
    check("midfill_busy", host_if.oBusy, 1);
    rst_n = 1'b0;
    step();
    check("abort_busy", host_if.oBusy, 0);
    check("abort_ready", host_if.oWriteReady, 0);
    check("abort_pixel", px_out, BLACK);
    rst_n = 1'b1;
    step();
    check("abort_release_ready", host_if.oWriteReady, 1);
    do_fill(CYAN, 1'b0, busy_n, ready_n);
    check("fill_cyan_busy_cycles", busy_n, 4800);
    read_px(10'd300, 10'd200, 1'b1, p);   check("cyan_300_200", p, CYAN);

    // Back-to-back writes to cell (3,3) with reads in the same and later cycles
    rwv[0] = '{1'b1, BLUE,   10'd24, 10'd24, CYAN};
    rwv[1] = '{1'b1, YELLOW, 10'd27, 10'd30, BLUE};
    rwv[2] = '{1'b0, BLACK,  10'd24, 10'd24, YELLOW};
    rwv[3] = '{1'b0, BLACK,  10'd31, 10'd31, YELLOW};
    host_if.iWriteCol = 7'd3; host_if.iWriteRow = 6'd3;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        host_if.iWriteValid = rwv[i].wv; host_if.iWriteColor = rwv[i].wcolor;
        px_col = rwv[i].col; px_row = rwv[i].row; px_vis = 1'b1;
      end else begin
        host_if.iWriteValid = 1'b0; px_vis = 1'b0;
      end
      step();
      if (i >= 1) check($sformatf("b2b%0d", i - 1), px_out, rwv[i - 1].exp);
    end

    // Randomised run against the reference model
    do_fill(MAGENTA, 1'b0, busy_n, ready_n);
    check("fill_magenta_busy_cycles", busy_n, 4800);
    for (int i = 0; i < NCELLS; i++) model[i] = MAGENTA;
    m_busy = 0; m_fill_idx = 0; m_fill_color = BLACK;

    for (int n = 0; n < 5000; n++) begin
      bit     wv, clr, vis;
      int     wc, wr, c, r;
      color_t wcol, ccol;
      if (exp_q.size() == 2) check("rand_pixel", px_out, exp_q.pop_front());
      wv   = ($urandom_range(0, 3) == 0);
      wc   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 7));
      wr   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))  : int'($urandom_range(0, 7));
      wcol = 3'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 1499) == 0);
      ccol = 3'($urandom_range(0, 7));
      vis  = ($urandom_range(0, 7) != 0);
      c    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 71));
      r    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(440, 1023)) : int'($urandom_range(0, 71));
      host_if.iWriteValid = wv; host_if.iWriteCol = 7'(wc); host_if.iWriteRow = 6'(wr);
      host_if.iWriteColor = wcol; host_if.iClear = clr; host_if.iClearColor = ccol;
      px_col = 10'(c); px_row = 10'(r); px_vis = vis;
      check("rand_ready", host_if.oWriteReady, m_busy ? 0 : 1);
      check("rand_busy", host_if.oBusy, m_busy ? 1 : 0);
      exp_q.push_back(exp_pixel(c, r, vis));
      model_edge(wv, wc, wr, wcol, clr, ccol);
      step();
    end
    host_if.iWriteValid = 1'b0; host_if.iClear = 1'b0; px_vis = 1'b0;
    while (exp_q.size() > 0) begin
      check("rand_pixel_drain", px_out, exp_q.pop_front());
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
